// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package mem_arbiter_pkg;

    localparam int unsigned DATA_W_DEF    = 32;
    localparam int unsigned MEM_WORDS_DEF = 64;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way request picker; on a tie the port not granted last wins.
// Tying last_m1_i high gives fixed priority to port 0.
module mem_arb_pick (
    input  logic [1:0] req_i,
    input  logic       last_m1_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        if (req_i == 2'b11) begin
            gnt_o = last_m1_i ? 2'b01 : 2'b10;
        end else begin
            gnt_o = req_i;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises CPU (m0) and loader/debug (m1) accesses onto one single-port memory.
// Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin ties; default is fixed m0 priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [DATA_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [DATA_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    localparam int unsigned IDX_W = DATA_W - 2;
    localparam logic [IDX_W-1:0] WORDS_LIM = IDX_W'(MEM_WORDS);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic              err0_q, err0_d, err1_q, err1_d;

    logic [1:0]        req_c;
    logic [1:0]        pick_c;
    logic              last_m1_c;
    logic              in_range_c;
    logic [DATA_W-1:0] resp_data_c;

    assign req_c = {m1_req, m0_req};

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    owner_e last_q, last_d;
    assign last_m1_c = (last_q == OWN_M1);
`else
    assign last_m1_c = 1'b1;
`endif

    mem_arb_pick u_pick (
        .req_i     (req_c),
        .last_m1_i (last_m1_c),
        .gnt_o     (pick_c)
    );

    // Byte offset is ignored; only the word index is range-checked.
    assign in_range_c  = (addr_q[DATA_W-1:2] < WORDS_LIM);
    assign resp_data_c = (!we_q && in_range_c) ? mem_rd : '0;

    // Next-state, grant and memory-pin decode.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        err0_d    = err0_q;
        err1_d    = err1_q;
        m0_gnt    = 1'b0;
        m1_gnt    = 1'b0;
        mem_we    = 1'b0;
        mem_a     = '0;
        mem_wd    = '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        last_d    = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|req_c) begin
                    m0_gnt  = pick_c[0];
                    m1_gnt  = pick_c[1];
                    owner_d = pick_c[1] ? OWN_M1 : OWN_M0;
                    we_d    = pick_c[1] ? m1_we    : m0_we;
                    addr_d  = pick_c[1] ? m1_addr  : m0_addr;
                    wdata_d = pick_c[1] ? m1_wdata : m0_wdata;
                    state_d = ST_ACCESS;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
                    last_d  = pick_c[1] ? OWN_M1 : OWN_M0;
`endif
                end
            end
            ST_ACCESS: begin
                mem_a  = addr_q;
                mem_wd = wdata_q;
                mem_we = we_q && in_range_c;
                if (owner_q == OWN_M1) begin
                    rvalid1_d = 1'b1;
                    rdata1_d  = resp_data_c;
                    err1_d    = !in_range_c;
                end else begin
                    rvalid0_d = 1'b1;
                    rdata0_d  = resp_data_c;
                    err0_d    = !in_range_c;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset drops any in-flight access; mem_we follows state_q so it falls at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_M0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            last_q    <= OWN_M1;
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            last_q    <= last_d;
`endif
        end
    end

    assign m0_rvalid = rvalid0_q;
    assign m0_rdata  = rdata0_q;
    assign m0_err    = err0_q;
    assign m1_rvalid = rvalid1_q;
    assign m1_rdata  = rdata1_q;
    assign m1_err    = err1_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port unified instruction/data memory between two requesters.
- Port 0 is the multicycle CPU. Port 1 is the board-level loader/debug port, used to write or inspect the program image on the Basys board.
- Sits between both requesters and the memory's clk/we/a/wd/rd pins.
- Serialises accesses with a small FSM, registers the read response, and flags out-of-range addresses.

Parameters:
- DATA_W, 32, data and address width.
- MEM_WORDS, 64, number of implemented memory words; word index = addr[31:2].

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- m0_req  in  1  CPU request; held until m0_gnt.
- m0_we  in  1  CPU write enable, qualified by m0_req.
- m0_addr  in  32  CPU byte address.
- m0_wdata  in  32  CPU write data.
- m0_gnt  out  1  request accepted this cycle.
- m0_rvalid  out  1  one-cycle response pulse.
- m0_rdata  out  32  read data, valid with m0_rvalid.
- m0_err  out  1  out-of-range flag, valid with m0_rvalid.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_err: same as port 0, for the loader/debug port.
- mem_we  out  1  to memory we.
- mem_a  out  32  to memory a.
- mem_wd  out  32  to memory wd.
- mem_rd  in  32  from memory rd (combinational read).

Behaviour:
- FSM states: IDLE, ACCESS. Reset state is IDLE.
- IDLE:
  - If any req is high, pick a winner and assert its gnt combinationally in the same cycle.
  - On that clock edge, latch owner, we, addr and wdata, then go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS (always exactly one cycle, then IDLE):
  - Drive mem_a = latched addr and mem_wd = latched wdata.
  - Drive mem_we = latched we AND in-range; the write commits at the end of this cycle.
  - On the clock edge, register rdata <= (read AND in-range) ? mem_rd : 0.
  - Also register err <= out-of-range, and pulse the owner's rvalid.
- Latency: gnt at cycle T, memory access at T+1, rvalid/rdata/err at T+2.
- Throughput: one access per 2 cycles. A new grant may coincide with the previous rvalid.
- Writes return rvalid with rdata = 0 (write acknowledge).
- In-range rule: addr[31:2] < MEM_WORDS. addr[1:0] is ignored (word-aligned access).
- Out-of-range:
  - Write is suppressed (mem_we = 0).
  - Read returns 0.
  - err = 1 with rvalid.
- In IDLE: mem_we = 0, mem_a = 0, mem_wd = 0.
- Arbitration (default build): fixed priority, m0 wins. m1 is served only when m0_req is low in IDLE, so it may starve.
- Simultaneous requests: exactly one gnt per cycle, never both. The loser keeps req high and is evaluated again at the next IDLE.
- rvalid and gnt are never asserted to a port that did not request.
- rdata/err hold their value between pulses; only the rvalid pulse qualifies them.
- Reset (any time, including mid-ACCESS):
  - State goes to IDLE immediately and the latched request is dropped.
  - mem_we deasserts asynchronously, so no write occurs.
  - All gnt, rvalid and err outputs are 0; rdata is 0.
  - The dropped requester must re-request.

Optional Feature:
- Macro: MEM_ARBITER_ROUND_ROBIN_EN.
- Defined: two-way round-robin.
  - A last-grant pointer updates on every grant.
  - When both ports request, the port not granted last wins.
  - Pointer resets to "m1 last", so m0 wins the first tie.
- Undefined: fixed m0 priority as above; no pointer flop.

Decomposition:
- Package mem_arbiter_pkg holds:
  - FSM state encoding (IDLE = 1'b0, ACCESS = 1'b1).
  - Default MEM_WORDS = 64.
  - Owner encoding (OWN_M0 = 0, OWN_M1 = 1).
- One sub-module, mem_arb_pick: combinational 2-way picker with an optional round-robin pointer input. Returns the grant vector; at most one bit is set.

Test Plan:
- Read: preload RAM[2] = E1802001; m0 read addr 0x08 -> m0_gnt at T, mem_a = 0x08 at T+1, m0_rvalid with rdata = E1802001 and err = 0 at T+2.
- Write-then-read: m1 writes 0xDEADBEEF to 0x10, then m1 reads 0x10 -> rdata = DEADBEEF; m0 sees no gnt/rvalid.
- Contention: m0 and m1 both read continuously.
  - Fixed build: only m0 is granted.
  - RR build: grants alternate m0, m1, m0, ...
- Out-of-range: m0 writes 0x100 (word 64), then reads 0x100 -> mem_we stays 0, rdata = 0, err = 1; RAM[0] unchanged.
- Reset mid-ACCESS: m1 write of 0x12345678 to 0x04 with reset asserted during ACCESS -> mem_we drops immediately, RAM[1] unchanged, no m1_rvalid, state IDLE.
